// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: each channel runs a modulo-(P+1) counter and
// drives a TOGGLE, STROBE or PWM output plus a one-cycle terminal-count flag.
module pulse_gen_multi #(
  parameter int CNT_W = 24,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic             sync,
  output logic [NCH-1:0]   pulse,
  output logic [NCH-1:0]   wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_STROBE = 2'b10,
    MODE_PWM    = 2'b11
  } mode_e;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      mode_e            mode_q, mode_d;
      logic [CNT_W-1:0] period_q, period_d;
      logic [CNT_W-1:0] duty_q, duty_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pulse_q, pulse_d;
      logic             wrap_q, wrap_d;
      logic             we_hit;
      logic             at_term;

      // Indices at or beyond NCH match no channel, so such writes fall through.
      assign we_hit  = cfg_we && (cfg_ch == CH_W'(gi));
      assign at_term = (cnt_q == period_q);

      always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        wrap_d   = wrap_q;
        if (we_hit) begin
          mode_d   = mode_e'(cfg_mode);
          period_d = cfg_period;
          duty_d   = cfg_duty;
          cnt_d    = '0;
          pulse_d  = 1'b0;
          wrap_d   = 1'b0;
        end else if (sync || (mode_q == MODE_OFF)) begin
          cnt_d   = '0;
          pulse_d = 1'b0;
          wrap_d  = 1'b0;
        end else begin
          wrap_d = at_term;
          cnt_d  = at_term ? '0 : cnt_q + CNT_W'(1);
          case (mode_q)
            MODE_TOGGLE: pulse_d = pulse_q ^ at_term;
            MODE_STROBE: pulse_d = at_term;
            MODE_PWM:    pulse_d = (cnt_q < duty_q);
            default:     pulse_d = 1'b0;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mode_q   <= MODE_OFF;
          period_q <= '0;
          duty_q   <= '0;
          cnt_q    <= '0;
          pulse_q  <= 1'b0;
          wrap_q   <= 1'b0;
        end else begin
          mode_q   <= mode_d;
          period_q <= period_d;
          duty_q   <= duty_d;
          cnt_q    <= cnt_d;
          pulse_q  <= pulse_d;
          wrap_q   <= wrap_d;
        end
      end

      assign pulse[gi] = pulse_q;
      assign wrap[gi]  = wrap_q;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: an analytic per-channel model (config + start cycle)
// pushes expected outputs each cycle; every scenario pops and compares them.
module tb_pulse_gen_multi;
  localparam int CNT_W = 24;
  localparam int NCH   = 4;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_duty = '0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   pulse;
  logic [NCH-1:0]   wrap;

  pulse_gen_multi #(.CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .sync(sync),
    .pulse(pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] p;
    logic [NCH-1:0] w;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     m_mode[NCH];
  longint m_p[NCH];
  longint m_d[NCH];
  longint m_start[NCH];

  // Expected {pulse, wrap} of one channel at sample t; n counts samples since
  // the last restart (n==0 is the sample right after the restarting edge).
  function automatic logic [1:0] exp_ch(int ch, longint t);
    longint n  = t - m_start[ch];
    longint pp = m_p[ch] + 1;
    logic   w, p;
    if (m_mode[ch] == 0) return 2'b00;
    w = (n > 0) && ((n % pp) == 0);
    case (m_mode[ch])
      1:       p = ((n / pp) % 2) == 1;
      2:       p = w;
      default: p = (n >= 1) && (((n - 1) % pp) < m_d[ch]);
    endcase
    return {p, w};
  endfunction

  // Applies the current inputs to the model, queues the expected post-edge
  // outputs, advances one clock and releases the one-cycle strobes.
  task automatic tick();
    exp_t       e;
    logic [1:0] pw;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0;
      end
    end else begin
      if (sync) begin
        for (int c = 0; c < NCH; c++) m_start[c] = cyc + 1;
        $display("cyc %0d sync", cyc);
      end
      if (cfg_we) begin
        $display("cyc %0d write ch=%0d mode=%0d P=%0d D=%0d sync=%0b", cyc, cfg_ch,
                 cfg_mode, cfg_period, cfg_duty, sync);
        if (int'(cfg_ch) < NCH) begin
          m_mode[cfg_ch]  = int'(cfg_mode);
          m_p[cfg_ch]     = longint'(cfg_period);
          m_d[cfg_ch]     = longint'(cfg_duty);
          m_start[cfg_ch] = cyc + 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      pw = exp_ch(c, cyc + 1);
      e.p[c] = pw[1];
      e.w[c] = pw[0];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic set_write(int ch, int mode, longint p, longint d);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
  endtask

  task automatic test_reset();
    exp_t e;
    #3;
    checks++;
    if ({pulse, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_async pulse=%b wrap=%b required 0", pulse, wrap);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) rst = 1'b0;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    set_write(0, 1, 50, 0);
    for (int k = 0; k < 160; k++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL toggle cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  task automatic test_pwm();
    exp_t e;
    longint duties[3] = '{3, 0, 10};
    for (int j = 0; j < 3; j++) begin
      set_write(1, 3, 9, duties[j]);
      for (int k = 0; k < 32; k++) begin
        tick();
        e = sb_q.pop_front();
        checks++;
        if ({pulse, wrap} !== {e.p, e.w}) begin
          errors++;
          $display("FAIL pwm_d%0d cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", duties[j], cyc, pulse, e.p, wrap, e.w);
        end
      end
    end
  endtask

  task automatic test_strobe();
    exp_t e;
    set_write(2, 2, 4, 0);
    for (int k = 0; k < 22; k++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL strobe cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  task automatic test_period_bounds();
    exp_t e;
    int     modes[5]  = '{1, 2, 3, 3, 1};
    longint pers[5]   = '{0, 0, 0, 0, 64'hFF_FFFF};
    longint dutys[5]  = '{0, 0, 1, 0, 0};
    for (int j = 0; j < 5; j++) begin
      set_write(3, modes[j], pers[j], dutys[j]);
      for (int k = 0; k < 8; k++) begin
        tick();
        e = sb_q.pop_front();
        checks++;
        if ({pulse, wrap} !== {e.p, e.w}) begin
          errors++;
          $display("FAIL bounds_%0d cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", j, cyc, pulse, e.p, wrap, e.w);
        end
      end
    end
  endtask

  task automatic test_sync();
    exp_t e;
    for (int k = 0; k < 50; k++) begin
      if (k == 0)  set_write(0, 1, 6, 0);
      if (k == 1)  set_write(3, 2, 10, 0);
      if (k == 18) sync = 1'b1;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL sync cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) set_write(NCH, 3, 2, 1);
      if (k == 12) begin
        set_write(0, 2, 3, 0);
        sync = 1'b1;
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL range_sync cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_write(1, 3, 9, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
    checks++;
    if (pulse[1] !== 1'b1) begin
      errors++;
      $display("FAIL pwm_high_before_reset pulse1=%b required 1", pulse[1]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({pulse, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_immediate pulse=%b wrap=%b required 0", pulse, wrap);
    end
    for (int k = 0; k < 14; k++) begin
      if (k == 3) rst = 1'b0;
      tick();
      e = sb_q.pop_front();
      checks++;
      if ({pulse, wrap} !== {e.p, e.w}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d pulse=%b exp=%b wrap=%b exp=%b", cyc, pulse, e.p, wrap, e.w);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_start[c] = 0;
    end
    test_reset();
    test_toggle();
    test_pwm();
    test_strobe();
    test_period_bounds();
    test_sync();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
